// File: rtl/rle_stream_decoder.sv
// rle_stream_decoder
//   Buffered run-length decoder. Packed {count, symbol} codewords are queued
//   in a small FIFO and each is expanded into count+1 copies of the symbol on
//   a backpressured valid/ready output stream.
//
// Ports
//   sclk        clock, rising edge
//   rst         synchronous reset, active low
//   in_valid    codeword present on in_code
//   in_code     {count[CNT_W-1:0], symbol[SYM_W-1:0]}
//   in_ready    FIFO can take a codeword this cycle (!fifo_full)
//   out_valid   out_sym holds a valid symbol
//   out_ready   consumer takes out_sym this cycle
//   out_sym     expanded symbol
//   out_last    final symbol of the current run
//   fifo_full   FIFO holds 2^FIFO_ADR_W entries
//   fifo_empty  FIFO holds no entries
//   stat_codes  (RLE_STATS_EN only) codewords popped, saturating
//   stat_syms   (RLE_STATS_EN only) output handshakes, saturating
//
// Build option: define RLE_STATS_EN to add the two statistics counters.

module rle_stream_decoder #(
  parameter int SYM_W      = 1,
  parameter int CNT_W      = 7,
  parameter int FIFO_ADR_W = 3
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [CNT_W+SYM_W-1:0] in_code,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SYM_W-1:0]       out_sym,
  output logic                   out_last,
  output logic                   fifo_full,
  output logic                   fifo_empty
`ifdef RLE_STATS_EN
  ,
  output logic [31:0]            stat_codes,
  output logic [31:0]            stat_syms
`endif
);

  localparam int DEPTH = 1 << FIFO_ADR_W;
  localparam logic [FIFO_ADR_W:0] FULL_OCC = (FIFO_ADR_W+1)'(DEPTH);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [SYM_W-1:0] sym;
  } code_t;

  typedef enum logic {IDLE, EMIT} state_t;

  // ---------------- codeword FIFO ----------------
  code_t                 mem [DEPTH];
  logic [FIFO_ADR_W-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADR_W:0]   occ;
  logic                  fresh;
  logic                  push, pop, avail;
  code_t                 head;

  assign fifo_full  = (occ == FULL_OCC);
  assign fifo_empty = (occ == '0);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr];
  // An entry written into an empty FIFO is held back from the decoder for one
  // cycle ('fresh'); this gives the two-edge accept-to-output latency while
  // fifo_empty itself still reflects true occupancy.
  assign avail      = !fifo_empty && !fresh;

  always_ff @(posedge sclk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  always_ff @(posedge sclk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      fresh  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
      fresh <= push && fifo_empty;
    end
  end

  // ---------------- run expander ----------------
  state_t           state, state_nx;
  logic [SYM_W-1:0] sym_reg, sym_nx;
  logic [CNT_W-1:0] rem, rem_nx;

  always_ff @(posedge sclk) begin
    if (!rst) begin
      state   <= IDLE;
      sym_reg <= '0;
      rem     <= '0;
    end else begin
      state   <= state_nx;
      sym_reg <= sym_nx;
      rem     <= rem_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sym_nx   = sym_reg;
    rem_nx   = rem;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (avail) begin
          pop      = 1'b1;
          sym_nx   = head.sym;
          rem_nx   = head.cnt;
          state_nx = EMIT;
        end
      end
      EMIT: begin
        // Nothing moves unless the consumer takes the current symbol.
        if (out_ready) begin
          if (rem != '0) begin
            rem_nx = rem - 1'b1;
          end else if (avail) begin
            // Chain straight into the next run without a bubble.
            pop    = 1'b1;
            sym_nx = head.sym;
            rem_nx = head.cnt;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_valid = (state == EMIT);
  assign out_sym   = sym_reg;
  assign out_last  = (state == EMIT) && (rem == '0);

`ifdef RLE_STATS_EN
  always_ff @(posedge sclk) begin
    if (!rst) begin
      stat_codes <= '0;
      stat_syms  <= '0;
    end else begin
      if (pop && stat_codes != 32'hFFFF_FFFF)
        stat_codes <= stat_codes + 1'b1;
      if (out_valid && out_ready && stat_syms != 32'hFFFF_FFFF)
        stat_syms <= stat_syms + 1'b1;
    end
  end
`endif

endmodule
